// File: rtl/axis_pixel_packer.sv
// Packs four 8-bit pixels into one 32-bit AXI4-Stream word, flags the last word of each frame.
// Optional start-of-frame sideband (m_axis_tuser) is built when PACKER_SOF_EN is defined.
module axis_pixel_packer #(
   parameter int unsigned IMG_WIDTH  = 512,
   parameter int unsigned IMG_HEIGHT = 512
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_data_valid,
   input  logic [7:0]  i_data,
   output logic        o_data_ready,
   output logic [31:0] m_axis_tdata,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        m_axis_tlast,
`ifdef PACKER_SOF_EN
   output logic        m_axis_tuser,
`endif
   output logic        o_frame_done
);

   localparam int unsigned WORDS = IMG_WIDTH * IMG_HEIGHT / 4;
   localparam int unsigned WC_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [WC_W-1:0] LAST_WORD = WC_W'(WORDS - 1);

   logic [1:0]      lane_q, lane_d;
   logic [23:0]     acc_q, acc_d;
   logic [WC_W-1:0] word_cnt_q, word_cnt_d;
   logic [31:0]     tdata_q, tdata_d;
   logic            tvalid_q, tvalid_d;
   logic            tlast_q, tlast_d;
   logic            frame_done_q, frame_done_d;
   logic            in_fire, out_fire, load;
`ifdef PACKER_SOF_EN
   logic            tuser_q, tuser_d;
`endif

   always_comb begin
      o_data_ready = (lane_q != 2'd3) || !tvalid_q || m_axis_tready;
      in_fire      = i_data_valid && o_data_ready;
      out_fire     = tvalid_q && m_axis_tready;
      load         = in_fire && (lane_q == 2'd3);

      lane_d       = lane_q;
      acc_d        = acc_q;
      word_cnt_d   = word_cnt_q;
      tdata_d      = tdata_q;
      tvalid_d     = tvalid_q;
      tlast_d      = tlast_q;
      frame_done_d = out_fire && tlast_q;
`ifdef PACKER_SOF_EN
      tuser_d      = tuser_q;
`endif

      if (in_fire) begin
         lane_d = lane_q + 2'd1;
         case (lane_q)
            2'd0:    acc_d[7:0]   = i_data;
            2'd1:    acc_d[15:8]  = i_data;
            2'd2:    acc_d[23:16] = i_data;
            default: acc_d        = acc_q;
         endcase
      end

      if (out_fire) begin
         tvalid_d = 1'b0;
         tlast_d  = 1'b0;
`ifdef PACKER_SOF_EN
         tuser_d  = 1'b0;
`endif
      end

      // A load overrides the clear above, so a drain and refill in one cycle leaves no bubble.
      if (load) begin
         tdata_d    = {i_data, acc_q};
         tvalid_d   = 1'b1;
         tlast_d    = (word_cnt_q == LAST_WORD);
         word_cnt_d = (word_cnt_q == LAST_WORD) ? '0 : word_cnt_q + 1'b1;
`ifdef PACKER_SOF_EN
         tuser_d    = (word_cnt_q == '0);
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lane_q       <= '0;
         acc_q        <= '0;
         word_cnt_q   <= '0;
         tdata_q      <= '0;
         tvalid_q     <= 1'b0;
         tlast_q      <= 1'b0;
         frame_done_q <= 1'b0;
`ifdef PACKER_SOF_EN
         tuser_q      <= 1'b0;
`endif
      end else begin
         lane_q       <= lane_d;
         acc_q        <= acc_d;
         word_cnt_q   <= word_cnt_d;
         tdata_q      <= tdata_d;
         tvalid_q     <= tvalid_d;
         tlast_q      <= tlast_d;
         frame_done_q <= frame_done_d;
`ifdef PACKER_SOF_EN
         tuser_q      <= tuser_d;
`endif
      end
   end

   assign m_axis_tdata  = tdata_q;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tlast  = tlast_q;
   assign o_frame_done  = frame_done_q;
`ifdef PACKER_SOF_EN
   assign m_axis_tuser  = tuser_q;
`endif

endmodule

// File: tb/tb_axis_pixel_packer.sv
// Directed bench for axis_pixel_packer with an 8x2 image (4 words per frame).
module tb_axis_pixel_packer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_data_valid = 1'b0;
   logic [7:0]  i_data = '0;
   logic        o_data_ready;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b0;
   logic        m_axis_tlast;
   logic        o_frame_done;
`ifdef PACKER_SOF_EN
   logic        m_axis_tuser;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   axis_pixel_packer #(
      .IMG_WIDTH (8),
      .IMG_HEIGHT(2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i_data_valid (i_data_valid),
      .i_data       (i_data),
      .o_data_ready (o_data_ready),
      .m_axis_tdata (m_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready),
      .m_axis_tlast (m_axis_tlast),
`ifdef PACKER_SOF_EN
      .m_axis_tuser (m_axis_tuser),
`endif
      .o_frame_done (o_frame_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_reset_outputs();
      check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
      check("rst_tlast", 32'(m_axis_tlast), 32'd0);
      check("rst_tdata", m_axis_tdata, 32'd0);
      check("rst_frame_done", 32'(o_frame_done), 32'd0);
      check("rst_ready", 32'(o_data_ready), 32'd1);
`ifdef PACKER_SOF_EN
      check("rst_tuser", 32'(m_axis_tuser), 32'd0);
`endif
   endtask

   // mode 0: tready always 1; mode 1: tready low for cycles 2..11;
   // mode 2: tready high only when the 4th byte of the next word is accepted (or input exhausted).
   task automatic run(input int npix, input logic [7:0] base, input int mode);
      int pix = 0, lane = 0, loaded = 0, recv = 0, cyc = 0, tail = 0;
      int last_hs = 0, dut_fd = 0;
      int nwords = npix / 4;
      logic fd_exp = 1'b0, stalled = 1'b0, tr, in_acc, out_acc, last_exp;
      logic [31:0] pdata = '0, wexp;
      logic plast = 1'b0;
      while (tail < 3) begin
         if (cyc >= 300) begin
            check("timeout", 32'd0, 32'd1);
            break;
         end
         @(negedge clk);
         i_data_valid = (pix < npix);
         i_data       = base + 8'(pix);
         case (mode)
            1:       tr = !(cyc >= 2 && cyc < 12);
            2:       tr = (lane == 3 && loaded > recv) || (pix >= npix);
            default: tr = 1'b1;
         endcase
         m_axis_tready = tr;
         #1;
         check("ready", 32'(o_data_ready), 32'(!(lane == 3 && loaded > recv && !tr)));
         check("tvalid", 32'(m_axis_tvalid), 32'(loaded > recv));
         check("frame_done", 32'(o_frame_done), 32'(fd_exp));
         if (o_frame_done) dut_fd++;
         if (stalled) begin
            check("stall_tdata", m_axis_tdata, pdata);
            check("stall_tlast", 32'(m_axis_tlast), 32'(plast));
         end
         in_acc  = i_data_valid && (lane != 3 || !(loaded > recv) || tr);
         out_acc = (loaded > recv) && tr;
         fd_exp  = 1'b0;
         if (out_acc) begin
            for (int j = 0; j < 4; j++) wexp[8*j +: 8] = base + 8'(4 * recv + j);
            last_exp = (recv % 4 == 3);
            check("tdata", m_axis_tdata, wexp);
            check("tlast", 32'(m_axis_tlast), 32'(last_exp));
`ifdef PACKER_SOF_EN
            check("tuser", 32'(m_axis_tuser), 32'(recv % 4 == 0));
`endif
            if (mode == 0 && recv > 0) check("spacing", 32'(cyc - last_hs), 32'd4);
            fd_exp  = last_exp;
            last_hs = cyc;
            recv++;
         end
         stalled = m_axis_tvalid && !tr;
         pdata   = m_axis_tdata;
         plast   = m_axis_tlast;
         if (in_acc) begin
            if (lane == 3) loaded++;
            lane = (lane + 1) % 4;
            pix++;
         end
         cyc++;
         if (pix >= npix && recv >= nwords) tail++;
      end
      i_data_valid = 1'b0;
      check("fd_count", 32'(dut_fd), 32'(npix / 16));
      check("words", 32'(recv), 32'(nwords));
   endtask

   initial begin
      #12;
      check_reset_outputs();
      @(negedge clk);
      rst = 1'b0;

      run(16, 8'h00, 0);   // continuous stream
      run(16, 8'h00, 1);   // backpressure for 10 cycles
      run(16, 8'h00, 2);   // drain and load in the same cycle

      run(6, 8'h20, 0);    // partial frame, then reset
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_reset_outputs();
      @(negedge clk);
      rst = 1'b0;
      run(16, 8'h10, 0);   // restart from lane 0, word 0

      run(32, 8'h40, 0);   // back-to-back frames

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/axis_pixel_packer.md
# axis_pixel_packer

Downstream stage of the image-processing top level. It consumes the 8-bit filtered pixel stream leaving the output buffer (`o_data`/`o_data_valid`/`i_data_ready`) and packs four pixels into one 32-bit AXI4-Stream word for the PS-side DMA. It asserts `tlast` on the final word of each frame and pulses a frame-done strobe, so the DMA transfer length matches one processed image.

## Interface
Parameters:
- `IMG_WIDTH`, default 512: pixels per line; must be a multiple of 4.
- `IMG_HEIGHT`, default 512: lines per frame; must be at least 1.

Ports:
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  reset, asynchronous and active-high.
- `i_data_valid`  in  1  upstream pixel valid.
- `i_data`  in  8  upstream pixel.
- `o_data_ready`  out  1  upstream ready; drives the output buffer's `i_data_ready`.
- `m_axis_tdata`  out  32  packed word, first pixel in [7:0], fourth pixel in [31:24].
- `m_axis_tvalid`  out  1  word valid.
- `m_axis_tready`  in  1  DMA ready.
- `m_axis_tlast`  out  1  high on the last word of the frame.
- `o_frame_done`  out  1  one-cycle pulse when the `tlast` word handshakes.

## Operation
- Upstream beat is accepted when `i_data_valid && o_data_ready`. Downstream beat is accepted when `m_axis_tvalid && m_axis_tready`.
- The byte lane counter `lane` (2 bits, 0..3) selects the accumulator byte written. The counter increments on every accepted pixel and wraps from 3 to 0.
- Accepting a pixel at lanes 0–2 writes the accumulator only.
- Accepting a pixel at lane 3 loads {i_data, acc[23:0]} into the output register, sets `m_axis_tvalid`, and loads `m_axis_tlast` = (word_cnt == IMG_WIDTH*IMG_HEIGHT/4 − 1).
- `word_cnt` counts words loaded into the output register. Its width is clog2(IMG_WIDTH*IMG_HEIGHT/4). It wraps to 0 after the `tlast` word is loaded. Frames are back-to-back with no gap required.
- `o_data_ready` = (lane != 3) || !m_axis_tvalid || m_axis_tready. This is combinational. It stalls only when the 4th byte has nowhere to go.
- Downstream handshake without a new load clears `m_axis_tvalid` and `m_axis_tlast`.
- Downstream handshake in the same cycle as a lane-3 load: the new word replaces the old one and `m_axis_tvalid` stays 1. No bubble occurs, and sustained throughput is 1 pixel/clk.
- `o_frame_done` is registered. It is high for exactly the cycle after the `tlast` word handshakes.
- While `m_axis_tvalid` = 1 and `m_axis_tready` = 0, `m_axis_tdata` and `m_axis_tlast` are held stable (AXIS rule).
- Upstream data presented while `o_data_ready` = 0 is not consumed. The counters do not move.

## Timing
- Reset values: `m_axis_tvalid` = 0, `m_axis_tlast` = 0, `m_axis_tdata` = 0, `o_frame_done` = 0, lane = 0, word_cnt = 0, accumulator = 0.
- `o_data_ready` = 1 out of reset.
- Latency: the 4th pixel accepted at edge N makes `m_axis_tvalid` = 1 after edge N; the word is visible in cycle N+1.
- `o_frame_done` is asserted the cycle after the `tlast` handshake edge.
- Reset asserted mid-frame: the partial accumulator and any pending output word are discarded. All outputs go to reset values asynchronously, and the next accepted pixel is treated as lane 0 of word 0.
- Reset release is synchronised by the system; the block takes no extra action.
- Downstream stall with lane < 3: upstream keeps flowing until lane = 3, then `o_data_ready` drops.

## Configuration
- `PACKER_SOF_EN` defined:
  - Adds output `m_axis_tuser`, 1 bit. It is high on the first word of each frame (word_cnt == 0 at load), with the same hold and clear rules as `m_axis_tlast`.
  - Reset value is 0.
- Not defined: the port is absent, and no start-of-frame logic is built.

## Test plan
Bench parameters: IMG_WIDTH = 8, IMG_HEIGHT = 2 (16 pixels, 4 words per frame).
- Reset: hold `rst` = 1 → all outputs at reset values, `o_data_ready` = 1.
- Continuous stream: pixels 0x00–0x0F, `m_axis_tready` held 1 → words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C.
  - One word every 4 clocks; `tlast` on the 4th word only.
  - `o_frame_done` pulses once, 1 cycle after the 4th handshake.
  - `m_axis_tuser` on the 1st word when `PACKER_SOF_EN` is defined.
- Backpressure: `m_axis_tready` = 0 for 10 cycles during the stream above.
  - `o_data_ready` drops exactly when lane = 3 and a word is pending.
  - `tdata`/`tlast` stay stable while stalled.
  - No pixel is lost or duplicated; same 4 words are delivered.
- Same-cycle drain and load: `m_axis_tready` = 1 exactly on the cycle the 4th byte of the next word is accepted → `tvalid` stays 1, and the next word appears with no idle cycle.
- Reset mid-frame: assert `rst` after 6 pixels, release, then send 0x10–0x1F → first word 0x13121110, and `tlast` on the 4th word after reset.
- Back-to-back frames: 32 consecutive pixels with ready held high → `tlast` on words 4 and 8, and two `o_frame_done` pulses.
